rsfq_tie_pattern_sync: RTL

Parametrised, multi-channel clocked constant and pattern source for the synchronous RSFQ cell library. Each channel emits, on every clock event, one of:
- a fixed 0;
- a fixed 1;
- a registered copy of its data input;
- a programmable repeating bit pattern.

It is the configurable successor to the single-channel clocked always-0 tie cell. It sits at the edges of test structures and datapaths wherever clocked constants or stimulus pulses are required.

---
 rtl/rsfq_tie_pkg.sv | 24 ++
 rtl/rsfq_tie_chan.sv | 72 +++++++
 rtl/rsfq_tie_pattern_sync.sv | 105 ++++++++++
 3 files changed

// File: rtl/rsfq_tie_pkg.sv
//==============================================================================
// Module      : rsfq_tie_pkg
// Description : Shared types and constants for the clocked tie/pattern source
//               (channel mode encoding and the default clock-to-q delay).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package rsfq_tie_pkg;

    // Per-channel output mode, encoded exactly as presented on cfg_mode
    typedef enum logic [1:0] {
        MODE_ZERO    = 2'd0,
        MODE_ONE     = 2'd1,
        MODE_PASS    = 2'd2,
        MODE_PATTERN = 2'd3
    } tie_mode_e;

    // Default clock-to-output delay of the cell, in picoseconds
    localparam int unsigned c_clk_q_ps_default = 10;

endpackage : rsfq_tie_pkg

`default_nettype wire

// File: rtl/rsfq_tie_chan.sv
//==============================================================================
// Module      : rsfq_tie_chan
// Description : One output channel: mode/length/pattern registers, the pattern
//               index counter and the registered output mux.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rsfq_tie_chan
    import rsfq_tie_pkg::*;
#(
    parameter int unsigned PAT_W = 16,
    parameter int unsigned LEN_W = $clog2(PAT_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             wr_en,
    input  tie_mode_e        wr_mode,
    input  logic [LEN_W-1:0] wr_len,
    input  logic [PAT_W-1:0] wr_pat,
    output logic             q
);

    tie_mode_e        r_mode;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_idx;
    logic [PAT_W-1:0] r_pat;
    logic             r_q;
    logic             w_q;
    logic             w_wrap;

    // Next output value, always taken from the mode in force before this edge
    always_comb begin
        w_q = 1'b0;
        case (r_mode)
            MODE_ZERO:    w_q = 1'b0;
            MODE_ONE:     w_q = 1'b1;
            MODE_PASS:    w_q = a;
            MODE_PATTERN: w_q = r_pat[r_idx];
            default:      w_q = 1'b0;
        endcase
    end

    assign w_wrap = (r_idx == r_len);

    // Channel state; a configuration write clears idx and wins over a wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode <= MODE_ZERO;
            r_len  <= '0;
            r_idx  <= '0;
            r_pat  <= '0;
            r_q    <= 1'b0;
        end else begin
            r_q <= w_q;
            if (wr_en) begin
                r_mode <= wr_mode;
                r_len  <= wr_len;
                r_pat  <= wr_pat;
                r_idx  <= '0;
            end else if (r_mode == MODE_PATTERN) begin
                r_idx <= w_wrap ? '0 : r_idx + LEN_W'(1);
            end
        end
    end

    assign q = r_q;

endmodule : rsfq_tie_chan

`default_nettype wire

// File: rtl/rsfq_tie_pattern_sync.sv
//==============================================================================
// Module      : rsfq_tie_pattern_sync
// Description : Multi-channel clocked constant / pass / pattern source with a
//               valid/ready configuration port. Holds the handshake, channel
//               decode and length clamp; channels live in rsfq_tie_chan.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rsfq_tie_pattern_sync
    import rsfq_tie_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned PAT_W    = 16,
    // Cell-library timing annotation; the RTL updates q at the clock edge
    parameter int unsigned CLK_Q_PS = c_clk_q_ps_default,
    localparam int unsigned CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int unsigned LEN_W   = $clog2(PAT_W)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] a,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [1:0]          cfg_mode,
    input  logic [LEN_W-1:0]    cfg_len,
    input  logic [PAT_W-1:0]    cfg_pat,
    output logic [CHANNELS-1:0] q
);

    // Elaboration-time parameter range checks
    if (CHANNELS < 1 || CHANNELS > 32) begin : g_chk_channels
        $error("rsfq_tie_pattern_sync: CHANNELS out of range 1..32");
    end
    if (PAT_W < 2 || PAT_W > 64) begin : g_chk_pat_w
        $error("rsfq_tie_pattern_sync: PAT_W out of range 2..64");
    end
    if (CLK_Q_PS > 1000) begin : g_chk_clk_q
        $error("rsfq_tie_pattern_sync: CLK_Q_PS unreasonably large");
    end

    // Handshake states: ready to accept, or the one-cycle apply gap
    localparam logic [0:0] c_st_apply = 1'b0;
    localparam logic [0:0] c_st_ready = 1'b1;

    localparam logic [LEN_W-1:0] c_len_max = LEN_W'(PAT_W - 1);

    logic [0:0]          r_state;
    logic [0:0]          w_state_next;
    logic                w_accept;
    logic [LEN_W-1:0]    w_len_clamped;
    tie_mode_e           w_mode;
    logic [CHANNELS-1:0] w_wr_en;

    // Handshake state register; reset parks in apply so ready is low under reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_apply;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Every accept is followed by exactly one apply cycle
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_ready: w_state_next = cfg_valid ? c_st_apply : c_st_ready;
            c_st_apply: w_state_next = c_st_ready;
            default:    w_state_next = c_st_apply;
        endcase
    end

    // Handshake output decode
    always_comb begin
        cfg_ready = (r_state == c_st_ready);
    end

    assign w_accept      = cfg_valid && cfg_ready;
    assign w_len_clamped = (cfg_len > c_len_max) ? c_len_max : cfg_len;
    assign w_mode        = tie_mode_e'(cfg_mode);

    // Out-of-range cfg_ch matches no channel, so the accept is simply dropped
    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        assign w_wr_en[g] = w_accept && (cfg_ch == CH_W'(g));

        rsfq_tie_chan #(
            .PAT_W (PAT_W),
            .LEN_W (LEN_W)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .a       (a[g]),
            .wr_en   (w_wr_en[g]),
            .wr_mode (w_mode),
            .wr_len  (w_len_clamped),
            .wr_pat  (cfg_pat),
            .q       (q[g])
        );
    end

endmodule : rsfq_tie_pattern_sync

`default_nettype wire
